jk_drive_sequencer: RTL and testbench
=====================================

Name: jk_drive_sequencer

Overview:
Upstream driver for a bank of WIDTH jk_ff instances: one J/K pair per bit.
- Accepts HOLD/CLR/SET/TOG commands over a valid/ready interface into a small FIFO.
- Replays each command on the j/k vectors for a programmable number of cycles.
- The downstream bank shares clk with this block and samples j/k at the next rising edge.

Parameters:
WIDTH, 4, number of flip-flops driven (width of j, k, cmd_mask)
DEPTH, 4, command FIFO entries; power of two, >= 2
CNT_W, 4, width of repeat count

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; equals !full && !flush (combinational)
cmd_op  in  2  00 HOLD, 01 CLR, 10 SET, 11 TOG
cmd_mask  in  WIDTH  bits affected by op
cmd_rep  in  CNT_W  issue cycles minus one
flush  in  1  synchronous abort/empty
j  out  WIDTH  registered J vector to bank
k  out  WIDTH  registered K vector to bank
busy  out  1  state==ISSUE or FIFO non-empty
done  out  1  registered one-cycle pulse, high during last issue cycle of each command

Behaviour:
Reset (rst_n low, asynchronous):
- FIFO empty; state IDLE; j=k=0; done=0; count=0.
- Pushes are ignored while rst_n is low.

FIFO push/pop:
- Push on a rising edge with cmd_valid && cmd_ready.
- No bypass: a full FIFO refuses a push even if a pop occurs the same edge.
- Simultaneous push and pop on a non-full FIFO is legal; occupancy is unchanged.
- Pointers wrap modulo DEPTH.

Op mapping of the active command onto j/k:
- HOLD: j=0, k=0.
- CLR: j=0, k=mask.
- SET: j=mask, k=0.
- TOG: j=mask, k=mask.
- Bits outside the mask are always 0/0.

FSM:
- IDLE:
  - j=k=0.
  - If FIFO non-empty at an edge: pop head, register j/k from it, count<=rep, go ISSUE.
  - Latency: command pushed at edge E appears on j/k after edge E+1.
- ISSUE:
  - Each edge with count!=0: count<=count-1; j/k held.
  - When count==0 (last cycle), done=1 for that cycle.
  - At the closing edge, if FIFO non-empty: pop and load the next command, staying ISSUE (zero-gap back-to-back).
  - Otherwise: go IDLE, j=k=0.
- rep=0: exactly one issue cycle. rep=2^CNT_W-1: 2^CNT_W issue cycles.

Flush (highest priority after reset), at the edge where flush=1:
- FIFO emptied; active command aborted; j=k=0; state IDLE; no done pulse.
- cmd_ready is low while flush is high, so no push occurs.

Reset mid-ISSUE: outputs go to 0 immediately, without waiting for a clock edge.

Optional Feature:
Macro: JK_SHADOW_EN

Defined:
- Adds input q_fb[WIDTH] (bank Q) and outputs shadow_q[WIDTH] and mismatch[1].
- shadow_q models the bank. At each edge each bit applies the JK function of the current j/k:
  - 00 hold, 01 clear, 10 set, 11 toggle.
- mismatch is a sticky register: mismatch <= mismatch | (q_fb != shadow_q).
- Reset: shadow_q=0, mismatch=0.
- Flush clears mismatch only; shadow_q keeps tracking the bank.

Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset release, push SET mask=4'b0101 rep=0 at edge E.
   -> j=0101, k=0000 for exactly cycle E+1; done=1 same cycle; then j=k=0, busy=0.
2. Push TOG mask=1111 rep=3.
   -> j=k=1111 for 4 consecutive cycles; done only on the 4th; a bank initialised at 0 ends at 0000.
3. Push 4 commands back-to-back with DEPTH=4 while IDLE, and hold cmd_valid for a 5th.
   -> first pop frees a slot so cmd_ready rises one cycle later; the 5th is accepted then.
   -> all 5 commands issue with zero gap; 5 done pulses.
4. Hold cmd_valid with the FIFO full and the head popping the same edge.
   -> no push on that edge (no bypass); push occurs on the following edge.
5. Flush during cycle 2 of a CLR rep=5 with 2 commands queued.
   -> j=k=0 next cycle; busy=0; no done pulse; queued commands never appear.
6. JK_SHADOW_EN: drive SET 0011, TOG 1111, CLR 0001 into a real jk_ff bank.
   -> shadow_q 0011, 1100, 1100 after each command; mismatch=0.
   -> force one q_fb bit wrong -> mismatch=1 and stays 1 until flush.

Source files
------------

// File: rtl/jk_drive_sequencer.sv
// Command sequencer that replays HOLD/CLR/SET/TOG commands onto the J/K inputs of a jk_ff bank.
// Optional bank shadow model and sticky mismatch flag are enabled with `define JK_SHADOW_EN.
module jk_drive_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_rep,
    input  logic             flush,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
`ifdef JK_SHADOW_EN
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] shadow_q,
    output logic             mismatch,
`endif
    output logic             done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] mask;
        logic [CNT_W-1:0] rep;
    } cmd_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, push, pop;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0] j_nxt, k_nxt;
    logic             done_nxt;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign busy      = (state == ISSUE) || !empty;

    // NOTE: storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{op: cmd_op, mask: cmd_mask, rep: cmd_rep};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            j     <= '0;
            k     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            j     <= j_nxt;
            k     <= k_nxt;
            done  <= done_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
                ISSUE: begin
                    if (count == '0) begin
                        if (!empty) pop = 1'b1;
                        else        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // done is precomputed so it is high in the cycle where count reaches zero.
    always_comb begin
        j_nxt     = '0;
        k_nxt     = '0;
        count_nxt = '0;
        done_nxt  = 1'b0;
        if (pop) begin
            case (head.op)
                OP_HOLD: ;
                OP_CLR:  k_nxt = head.mask;
                OP_SET:  j_nxt = head.mask;
                OP_TOG: begin
                    j_nxt = head.mask;
                    k_nxt = head.mask;
                end
                default: ;
            endcase
            count_nxt = head.rep;
            done_nxt  = (head.rep == '0);
        end else if (state_nxt == ISSUE) begin
            j_nxt     = j;
            k_nxt     = k;
            count_nxt = count - CNT_W'(1);
            done_nxt  = (count == CNT_W'(1));
        end
    end

`ifdef JK_SHADOW_EN
    // Shadow follows Q+ = J&~Q | ~K&Q, the same function the bank applies to j/k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            mismatch <= 1'b0;
        end else begin
            shadow_q <= (j & ~shadow_q) | (~k & shadow_q);
            if (flush) mismatch <= 1'b0;
            else       mismatch <= mismatch | (q_fb != shadow_q);
        end
    end
`endif

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Self-checking bench for jk_drive_sequencer: per-cycle scoreboard, op-mapping vector table, corner sequences.
module tb_jk_drive_sequencer;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, flush, busy, done;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_mask, j, k;
    logic [CW-1:0] cmd_rep;
    logic [W-1:0]  bank;
`ifdef JK_SHADOW_EN
    logic [W-1:0]  q_fb, shadow_q, inject;
    logic          mismatch;
    assign q_fb = bank ^ inject;
`endif

    jk_drive_sequencer #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_rep(cmd_rep), .flush(flush),
        .j(j), .k(k), .busy(busy),
`ifdef JK_SHADOW_EN
        .q_fb(q_fb), .shadow_q(shadow_q), .mismatch(mismatch),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Behavioural bank of jk_ff flops sampling j/k at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank <= '0;
        else begin
            for (int b = 0; b < W; b++) begin
                case ({j[b], k[b]})
                    2'b01:   bank[b] <= 1'b0;
                    2'b10:   bank[b] <= 1'b1;
                    2'b11:   bank[b] <= ~bank[b];
                    default: bank[b] <= bank[b];
                endcase
            end
        end
    end

    // Scoreboard: accepted commands queue up; the issue engine consumes them one per command.
    typedef struct packed {
        logic [1:0]    op;
        logic [W-1:0]  mask;
        logic [CW-1:0] rep;
    } cmd_t;

    cmd_t         sb_q[$];
    cmd_t         m_cmd;
    logic [W-1:0] m_j = '0, m_k = '0;
    logic         m_done = 1'b0, m_active = 1'b0, m_acc;
    int           m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            m_active = 1'b0; m_done = 1'b0; m_cnt = 0; m_j = '0; m_k = '0;
        end else begin
            m_acc = cmd_valid && (sb_q.size() < D) && !flush;
            if (flush) begin
                sb_q.delete();
                m_active = 1'b0; m_done = 1'b0; m_cnt = 0; m_j = '0; m_k = '0;
            end else if (m_active && m_cnt != 0) begin
                m_cnt--;
                m_done = (m_cnt == 0);
            end else if (sb_q.size() > 0) begin
                m_cmd = sb_q.pop_front();
                case (m_cmd.op)
                    2'b00:   begin m_j = '0;         m_k = '0;         end
                    2'b01:   begin m_j = '0;         m_k = m_cmd.mask; end
                    2'b10:   begin m_j = m_cmd.mask; m_k = '0;         end
                    default: begin m_j = m_cmd.mask; m_k = m_cmd.mask; end
                endcase
                m_cnt    = int'(m_cmd.rep);
                m_active = 1'b1;
                m_done   = (m_cmd.rep == '0);
            end else begin
                m_active = 1'b0; m_done = 1'b0; m_j = '0; m_k = '0;
            end
            if (m_acc) sb_q.push_back({cmd_op, cmd_mask, cmd_rep});
        end
    end

    bit chk_en    = 1'b0;
    int done_seen = 0;

    always @(posedge clk) begin
        #1;
        if (chk_en && rst_n) begin
            check("sb_j", j, m_j);
            check("sb_k", k, m_k);
            check("sb_done", done, m_done);
            check("sb_busy", busy, m_active || (sb_q.size() > 0));
            check("sb_ready", cmd_ready, (sb_q.size() < D) && !flush);
            if (done) done_seen++;
        end
    end

    task automatic push(input logic [1:0] op, input logic [W-1:0] m, input logic [CW-1:0] r, input bit hold);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_rep = r;
        #1;
        while (!cmd_ready) begin
            n++;
            if (n > 200) begin
                bound_expired("push");
                cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        if (!hold) begin
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            @(posedge clk);
            #2;
            if (done) return;
        end
        bound_expired("wait_done");
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            @(posedge clk);
            #2;
            if (!busy) return;
        end
        bound_expired("wait_idle");
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  mask;
        logic [CW-1:0] rep;
        logic [W-1:0]  exp_j;
        logic [W-1:0]  exp_k;
    } vec_t;

    vec_t tv[6];
    int   d0, cj, cd;
    logic [W-1:0] b0;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{2'b00, 4'b1111, 4'd0, 4'b0000, 4'b0000};
        tv[1] = '{2'b01, 4'b1010, 4'd1, 4'b0000, 4'b1010};
        tv[2] = '{2'b10, 4'b0110, 4'd2, 4'b0110, 4'b0000};
        tv[3] = '{2'b11, 4'b1001, 4'd0, 4'b1001, 4'b1001};
        tv[4] = '{2'b01, 4'b1111, 4'd0, 4'b0000, 4'b1111};
        tv[5] = '{2'b10, 4'b1000, 4'd15, 4'b1000, 4'b0000};

        cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_rep = '0; flush = 1'b0;
`ifdef JK_SHADOW_EN
        inject = '0;
`endif

        // Reset state
        #12;
        check("rst_j", j, 0);
        check("rst_k", k, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single SET, rep=0: one issue cycle, done in that cycle
        push(2'b10, 4'b0101, 4'd0, 1'b0);
        @(posedge clk); #1;
        check("t1_j", j, 4'b0101);
        check("t1_k", k, 4'b0000);
        check("t1_done", done, 1);
        @(posedge clk); #1;
        check("t1_j_after", j, 0);
        check("t1_busy_after", busy, 0);

        // TOG all bits for 4 cycles returns the bank to its starting value
        repeat (2) @(posedge clk);
        b0 = bank;
        cj = 0; cd = 0;
        push(2'b11, 4'b1111, 4'd3, 1'b0);
        repeat (6) begin
            @(posedge clk); #2;
            if (j == 4'b1111 && k == 4'b1111) cj++;
            if (done) cd++;
        end
        check("t2_issue_cycles", cj, 4);
        check("t2_done_pulses", cd, 1);
        check("t2_bank", bank, b0);

        // Op mapping table, including rep at its maximum
        for (int i = 0; i < 6; i++) begin
            push(tv[i].op, tv[i].mask, tv[i].rep, 1'b0);
            wait_done(40);
            check($sformatf("tv%0d_j", i), j, tv[i].exp_j);
            check($sformatf("tv%0d_k", i), k, tv[i].exp_k);
            wait_idle(10);
        end

        // Back-to-back stream with cmd_valid held: FIFO fills, full+pop edge refuses the push
        d0 = done_seen;
        for (int i = 0; i < 7; i++) begin
            push(2'(i), 4'(i + 1), 4'd2, i != 6);
        end
        wait_idle(100);
        check("t3_done_pulses", done_seen - d0, 7);

        // Flush in cycle 2 of CLR rep=5 with two commands queued
        d0 = done_seen;
        push(2'b01, 4'b1111, 4'd5, 1'b1);
        push(2'b10, 4'b0011, 4'd0, 1'b1);
        push(2'b11, 4'b1100, 4'd1, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("t5_ready_in_flush", cmd_ready, 0);
        @(posedge clk); #1;
        check("t5_j", j, 0);
        check("t5_k", k, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        @(negedge clk);
        flush = 1'b0;
        cj = 0;
        repeat (8) begin
            @(posedge clk); #2;
            if (j != 0 || k != 0) cj++;
        end
        check("t5_no_replay", cj, 0);
        check("t5_no_done", done_seen - d0, 0);

        // Asynchronous reset mid-ISSUE clears outputs without a clock edge
        push(2'b11, 4'b1111, 4'd7, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_j", j, 0);
        check("arst_k", k, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef JK_SHADOW_EN
        // Shadow tracks the bank; a corrupted q_fb bit sets a sticky mismatch until flush
        push(2'b10, 4'b0011, 4'd0, 1'b0);
        wait_idle(10);
        @(posedge clk); #2;
        check("sh_set", shadow_q, 4'b0011);
        push(2'b11, 4'b1111, 4'd0, 1'b0);
        wait_idle(10);
        @(posedge clk); #2;
        check("sh_tog", shadow_q, 4'b1100);
        push(2'b01, 4'b0001, 4'd0, 1'b0);
        wait_idle(10);
        @(posedge clk); #2;
        check("sh_clr", shadow_q, 4'b1100);
        check("sh_bank", bank, 4'b1100);
        check("sh_mismatch0", mismatch, 0);
        @(negedge clk); inject = 4'b0001;
        @(negedge clk); inject = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        check("sh_mismatch_sticky", mismatch, 1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #2;
        check("sh_mismatch_flush", mismatch, 0);
        check("sh_keeps_tracking", shadow_q, 4'b1100);
`endif

        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
